rv_instr_encoder: RTL and testbench

//  Inverse of the control unit's decode: packs RV32I instruction fields (class, funct3, alt bit,
//  rd/rs1/rs2, 32-bit immediate) into legal 32-bit machine words and streams them, with

---
 rtl/rv_instr_encoder_if.sv | 35 +++
 rtl/rv_instr_encoder.sv | 152 +++++++++++++++
 tb/tb_rv_instr_encoder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_instr_encoder_if.sv
// Handshake and field bundle between an instruction-stream producer and the
// RV32I encoder; master drives requests, slave is the encoder.
interface rv_instr_encoder_if #(
  parameter int unsigned DEPTH = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [3:0]                in_class;
  logic [2:0]                in_funct3;
  logic                      in_alt;
  logic [4:0]                in_rd;
  logic [4:0]                in_rs1;
  logic [4:0]                in_rs2;
  logic [31:0]               in_imm;
  logic                      load_addr;
  logic [31:0]               addr_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_addr;
  logic [31:0]               out_data;
  logic                      err;
  logic [$clog2(DEPTH):0]    level;

  modport master (
    output in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
           load_addr, addr_in, out_ready,
    input  in_ready, out_valid, out_addr, out_data, err, level
  );

  modport slave (
    input  in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
           load_addr, addr_in, out_ready,
    output in_ready, out_valid, out_addr, out_data, err, level
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// RV32I field-to-machine-word encoder with legality checking, an output FIFO
// and an auto-incrementing word address for the instruction-memory loader.
module rv_instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst_n,
  rv_instr_encoder_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [3:0] C_R      = 4'd0;
  localparam logic [3:0] C_OPIMM  = 4'd1;
  localparam logic [3:0] C_LOAD   = 4'd2;
  localparam logic [3:0] C_STORE  = 4'd3;
  localparam logic [3:0] C_BRANCH = 4'd4;
  localparam logic [3:0] C_LUI    = 4'd5;
  localparam logic [3:0] C_AUIPC  = 4'd6;
  localparam logic [3:0] C_JAL    = 4'd7;
  localparam logic [3:0] C_JALR   = 4'd8;

  function automatic logic is_legal(input logic [3:0] cls, input logic [2:0] f3,
                                    input logic alt, input logic [31:0] imm);
    logic ok_i, ok_b, ok_j, ok_sh, alt_ok, legal;
    // Range checks are written as "value survives sign-extension from the field width".
    ok_i   = (imm == {{20{imm[11]}}, imm[11:0]});
    ok_b   = (imm == {{19{imm[12]}}, imm[12:0]}) && (imm[0] == 1'b0);
    ok_j   = (imm == {{11{imm[20]}}, imm[20:0]}) && (imm[0] == 1'b0);
    ok_sh  = (imm[31:5] == 27'd0);
    alt_ok = !alt || ((cls == C_R) && ((f3 == 3'b000) || (f3 == 3'b101)))
                  || ((cls == C_OPIMM) && (f3 == 3'b101));
    case (cls)
      C_R:             legal = 1'b1;
      C_OPIMM:         legal = ((f3 == 3'b001) || (f3 == 3'b101)) ? ok_sh : ok_i;
      C_LOAD:          legal = ok_i && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      C_STORE:         legal = ok_i && (f3 <= 3'b010);
      C_BRANCH:        legal = ok_b && (f3 != 3'b010) && (f3 != 3'b011);
      C_LUI, C_AUIPC:  legal = (imm[11:0] == 12'd0);
      C_JAL:           legal = ok_j;
      C_JALR:          legal = ok_i;
      default:         legal = 1'b0;
    endcase
    return legal && alt_ok;
  endfunction

  function automatic logic [31:0] encode(input logic [3:0] cls, input logic [2:0] f3,
                                         input logic alt, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
    logic [6:0]  f7;
    logic [31:0] w;
    f7 = alt ? 7'b0100000 : 7'b0000000;
    case (cls)
      C_R:      w = {f7, rs2, rs1, f3, rd, 7'b0110011};
      C_OPIMM:  w = ((f3 == 3'b001) || (f3 == 3'b101))
                    ? {f7, imm[4:0], rs1, f3, rd, 7'b0010011}
                    : {imm[11:0], rs1, f3, rd, 7'b0010011};
      C_LOAD:   w = {imm[11:0], rs1, f3, rd, 7'b0000011};
      C_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      C_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      C_LUI:    w = {imm[31:12], rd, 7'b0110111};
      C_AUIPC:  w = {imm[31:12], rd, 7'b0010111};
      C_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      C_JALR:   w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      default:  w = 32'd0;
    endcase
    return w;
  endfunction

  logic [31:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0] level_r, level_nxt_s;
  logic [31:0]      out_data_r, out_addr_r, head_nxt_s, word_s;
  logic             out_valid_r, in_ready_r, err_r;
  logic             accept_s, legal_s, push_s, pop_s, reject_s;

  assign word_s   = encode(bus.in_class, bus.in_funct3, bus.in_alt, bus.in_rd,
                           bus.in_rs1, bus.in_rs2, bus.in_imm);
  assign legal_s  = is_legal(bus.in_class, bus.in_funct3, bus.in_alt, bus.in_imm);
  assign accept_s = bus.in_valid && in_ready_r;
  assign push_s   = accept_s && legal_s;
  assign reject_s = accept_s && !legal_s;
  assign pop_s    = out_valid_r && bus.out_ready;

  // Next occupancy and the word that will sit at the head after this edge.
  always_comb begin
    level_nxt_s = level_r + LVL_W'(push_s) - LVL_W'(pop_s);
    head_nxt_s  = out_data_r;
    if (pop_s) begin
      if (level_r > LVL_W'(1)) begin
        head_nxt_s = mem_r[rd_ptr_r + PTR_W'(1)];
      end else if (push_s) begin
        head_nxt_s = word_s;
      end else begin
        head_nxt_s = out_data_r;
      end
    end else if ((level_r == LVL_W'(0)) && push_s) begin
      head_nxt_s = word_s;
    end else begin
      head_nxt_s = out_data_r;
    end
  end

  // FIFO storage, pointers, address counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= 32'd0;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      out_data_r  <= 32'd0;
      out_addr_r  <= BASE_ADDR;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      err_r       <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= word_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      // An explicit reload wins over the post-pop increment.
      if (bus.load_addr) begin
        out_addr_r <= {bus.addr_in[31:2], 2'b00};
      end else if (pop_s) begin
        out_addr_r <= out_addr_r + 32'd4;
      end
      if (reject_s) begin
        err_r <= 1'b1;
      end else if (bus.load_addr) begin
        err_r <= 1'b0;
      end
      level_r     <= level_nxt_s;
      out_data_r  <= head_nxt_s;
      out_valid_r <= (level_nxt_s != LVL_W'(0));
      in_ready_r  <= (level_nxt_s != LVL_W'(DEPTH));
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_addr  = out_addr_r;
  assign bus.out_data  = out_data_r;
  assign bus.err       = err_r;
  assign bus.level     = level_r;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed self-checking bench for rv_instr_encoder (DEPTH=4, BASE_ADDR=0).
module tb_rv_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic acc;

  rv_instr_encoder_if #(.DEPTH(4)) bus ();

  rv_instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    bus.in_class  = cls;
    bus.in_funct3 = f3;
    bus.in_alt    = alt;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
  endtask

  task automatic send(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    set_fields(cls, f3, alt, rd, rs1, rs2, imm);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [3:0] cls, input logic [2:0] f3,
                     input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm,
                     input logic [31:0] exp_word, input logic [31:0] exp_addr);
    chk({tag, "_pre_valid"}, 32'(bus.out_valid), 32'd0);
    send(cls, f3, alt, rd, rs1, rs2, imm);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"}, bus.out_data, exp_word);
    chk({tag, "_addr"}, bus.out_addr, exp_addr);
    chk({tag, "_level"}, 32'(bus.level), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_empty"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_hold"}, bus.out_data, exp_word);
    chk({tag, "_next_addr"}, bus.out_addr, exp_addr + 32'd4);
  endtask

  task automatic illegal(input string tag, input logic [3:0] cls, input logic [2:0] f3,
                         input logic [31:0] imm);
    send(cls, f3, 1'b0, 5'd1, 5'd1, 5'd1, imm);
    chk({tag, "_err"}, 32'(bus.err), 32'd1);
    chk({tag, "_level"}, 32'(bus.level), 32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic reload(input logic [31:0] a);
    bus.load_addr = 1'b1;
    bus.addr_in   = a;
    step();
    bus.load_addr = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.load_addr = 1'b0;
    bus.addr_in   = 32'd0;
    set_fields(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_addr", bus.out_addr, 32'h0000_0000);
    chk("rst_data", bus.out_data, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Encoding vectors, each pushed into an empty FIFO then popped.
    vec("add",   4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3, 32'd0);
    vec("addi",  4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,   32'hFFF00093, 32'd4);
    vec("sw",    4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423, 32'd8);
    vec("beq",   4'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC,   32'hFE000EE3, 32'd12);
    vec("lui",   4'd5, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000,   32'h123452B7, 32'd16);
    vec("srai",  4'd1, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,          32'h40315093, 32'd20);
    vec("jal",   4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF, 32'd24);

    // Illegal requests are consumed without a push; reload clears err.
    illegal("b_odd", 4'd4, 3'b000, 32'd3);
    reload(32'h0000_0200);
    chk("clr1_err", 32'(bus.err), 32'd0);
    chk("clr1_addr", bus.out_addr, 32'h0000_0200);
    illegal("ld_f3", 4'd2, 3'b011, 32'd0);
    reload(32'h0000_0203);
    chk("clr2_err", 32'(bus.err), 32'd0);
    chk("clr2_addr", bus.out_addr, 32'h0000_0200);
    illegal("cls12", 4'd12, 3'b000, 32'd0);
    reload(32'h0000_0000);
    chk("clr3_err", 32'(bus.err), 32'd0);
    chk("clr3_addr", bus.out_addr, 32'h0000_0000);

    // Fill to full with the sink stalled; the fifth request must wait.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_fields(4'd5, 3'd0, 1'b0, 5'(i), 5'd0, 5'd0, 32'd0);
      step();
    end
    chk("full_level", 32'(bus.level), 32'd4);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    set_fields(4'd5, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'd0);
    step();
    chk("full_hold_level", 32'(bus.level), 32'd4);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("drain%0d_data", k), bus.out_data, (32'(k) << 7) | 32'h37);
      chk($sformatf("drain%0d_addr", k), bus.out_addr, 32'(k) * 32'd4);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) begin
        bus.in_valid = 1'b0;
      end
    end
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    chk("drain_addr", bus.out_addr, 32'd20);
    chk("drain_level", 32'(bus.level), 32'd0);

    // Streaming push+pop with an address reload mid-stream.
    bus.in_valid = 1'b1;
    set_fields(4'd5, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'd0);
    step();
    chk("st0_addr", bus.out_addr, 32'd20);
    chk("st0_data", bus.out_data, 32'h0000_0537);
    set_fields(4'd5, 3'd0, 1'b0, 5'd11, 5'd0, 5'd0, 32'd0);
    step();
    chk("st1_addr", bus.out_addr, 32'd24);
    chk("st1_data", bus.out_data, 32'h0000_05B7);
    chk("st1_level", 32'(bus.level), 32'd1);
    set_fields(4'd5, 3'd0, 1'b0, 5'd12, 5'd0, 5'd0, 32'd0);
    bus.load_addr = 1'b1;
    bus.addr_in   = 32'h0000_0100;
    step();
    bus.load_addr = 1'b0;
    chk("st2_addr", bus.out_addr, 32'h0000_0100);
    chk("st2_data", bus.out_data, 32'h0000_0637);
    set_fields(4'd5, 3'd0, 1'b0, 5'd13, 5'd0, 5'd0, 32'd0);
    step();
    chk("st3_addr", bus.out_addr, 32'h0000_0104);
    chk("st3_data", bus.out_data, 32'h0000_06B7);
    chk("st3_level", 32'(bus.level), 32'd1);

    // Asynchronous reset in the middle of the stream.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_addr", bus.out_addr, 32'h0000_0000);
    chk("arst_level", 32'(bus.level), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_data", bus.out_data, 32'd0);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
